// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: rotating-priority one-hot arbiter with registered, held grants.
// Optional grant timeout is built when ARB_TIMEOUT_EN is defined.
module round_robin_arbiter #(
  parameter int NREQ = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id,
  output logic            busy,
  output logic            timeout
);
  typedef enum logic {S_IDLE, S_GRANT} state_t;
  state_t r_state;
  logic [NREQ-1:0] r_ptr;
  logic [2*NREQ-1:0] w_dbl, w_sel;
  logic [NREQ-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic w_rel, w_to;
  // isolate the first request at or above ptr, wrapping through the upper copy
  assign w_dbl = {req, req};
  assign w_sel = w_dbl & ~(w_dbl - {{NREQ{1'b0}}, r_ptr});
  assign w_win = w_sel[NREQ-1:0] | w_sel[2*NREQ-1:NREQ];
  assign w_rel = done | ~|(req & grant);
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) w_idx = w_win[i] ? IW'(i) : w_idx;
  end
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;
  logic [CW-1:0] r_cnt;
  assign w_to = r_state == S_GRANT && r_cnt == CW'(MAX_HOLD - 1);
  always_ff @(posedge clk) begin
    if (reset || r_state == S_IDLE) r_cnt <= '0;
    else if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + 1'b1;
  end
`else
  assign w_to = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= NREQ'(1);
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (r_state == S_IDLE) begin
        if (|req) begin
          r_state  <= S_GRANT;
          r_ptr    <= {w_win[NREQ-2:0], w_win[NREQ-1]};
          grant    <= w_win;
          grant_id <= w_idx;
          busy     <= 1'b1;
        end
      end else if (w_rel || w_to) begin
        r_state  <= S_IDLE;
        grant    <= '0;
        grant_id <= '0;
        busy     <= 1'b0;
        timeout  <= ~w_rel;
      end
    end
  end
endmodule
